// File: rtl/typhoon_pkg.sv
// ============================================================================
// Module   : typhoon_pkg
// Brief    : Shared enums for the tile shader (depth-test mode, FSM state).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package typhoon_pkg;

    typedef enum logic [1:0] {
        ZM_ALWAYS = 2'd0,
        ZM_LESS   = 2'd1,
        ZM_LEQUAL = 2'd2,
        ZM_NEVER  = 2'd3
    } z_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tile_shader_if.sv
// ============================================================================
// Module   : tile_shader_if
// Brief    : Command, depth-read and pixel-write signals of the tile shader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tile_shader_if #(
    parameter int TILE_DIM  = 8,
    parameter int NUM_LANES = 4,
    parameter int COLOR_W   = 16,
    parameter int Z_W       = 16,
    parameter int COORD_W   = 10
);
    import typhoon_pkg::*;

    localparam int AW = $clog2(TILE_DIM);

    logic                     start;
    logic [COORD_W-1:0]       tile_x;
    logic [COORD_W-1:0]       tile_y;
    logic [COORD_W-1:0]       box_x;
    logic [COORD_W-1:0]       box_y;
    logic [COORD_W-1:0]       box_w;
    logic [COORD_W-1:0]       box_h;
    logic [COLOR_W-1:0]       frag_color;
    logic [Z_W-1:0]           frag_z;
    z_mode_e                  z_mode;
    logic                     busy;
    logic                     done;
    logic [AW-1:0]            rd_x;
    logic [AW-1:0]            rd_y;
    logic [NUM_LANES*Z_W-1:0] rd_z;
    logic [NUM_LANES-1:0]     wr_en;
    logic [AW-1:0]            wr_x;
    logic [AW-1:0]            wr_y;
    logic [COLOR_W-1:0]       wr_color;
    logic [Z_W-1:0]           wr_z;

    modport master (
        output start, tile_x, tile_y, box_x, box_y, box_w, box_h,
               frag_color, frag_z, z_mode, rd_z,
        input  busy, done, rd_x, rd_y, wr_en, wr_x, wr_y, wr_color, wr_z
    );

    modport slave (
        input  start, tile_x, tile_y, box_x, box_y, box_w, box_h,
               frag_color, frag_z, z_mode, rd_z,
        output busy, done, rd_x, rd_y, wr_en, wr_x, wr_y, wr_color, wr_z
    );

endinterface

`default_nettype wire

// File: rtl/tile_shader_z_test.sv
// ============================================================================
// Module   : z_test
// Brief    : One shading lane: rectangle coverage AND unsigned depth compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z_test
    import typhoon_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int Z_W     = 16,
    parameter int AW      = 3,
    parameter int LANE    = 0
) (
    input  wire logic [COORD_W-1:0] i_tile_x,
    input  wire logic [COORD_W-1:0] i_tile_y,
    input  wire logic [AW-1:0]      i_grp_x,
    input  wire logic [AW-1:0]      i_grp_y,
    input  wire logic [COORD_W-1:0] i_box_x,
    input  wire logic [COORD_W-1:0] i_box_y,
    input  wire logic [COORD_W-1:0] i_box_w,
    input  wire logic [COORD_W-1:0] i_box_h,
    input  wire logic [Z_W-1:0]     i_frag_z,
    input  wire logic [Z_W-1:0]     i_rd_z,
    input  wire z_mode_e            i_z_mode,
    output logic                    o_pass
);

    localparam int XW = COORD_W + 1;

    // One extra bit keeps box ends near the top of the screen from wrapping
    logic [XW-1:0] w_px;
    logic [XW-1:0] w_py;
    logic [XW-1:0] w_x_end;
    logic [XW-1:0] w_y_end;
    logic          w_cov;
    logic          w_depth_ok;

    assign w_px    = XW'(i_tile_x) + XW'(i_grp_x) + XW'(LANE);
    assign w_py    = XW'(i_tile_y) + XW'(i_grp_y);
    assign w_x_end = XW'(i_box_x) + XW'(i_box_w);
    assign w_y_end = XW'(i_box_y) + XW'(i_box_h);

    assign w_cov = (w_px >= XW'(i_box_x)) && (w_px < w_x_end) &&
                   (w_py >= XW'(i_box_y)) && (w_py < w_y_end);

    always_comb begin
        w_depth_ok = 1'b0;
        case (i_z_mode)
            ZM_ALWAYS: w_depth_ok = 1'b1;
            ZM_LESS:   w_depth_ok = (i_frag_z <  i_rd_z);
            ZM_LEQUAL: w_depth_ok = (i_frag_z <= i_rd_z);
            default:   w_depth_ok = 1'b0;
        endcase
    end

    assign o_pass = w_cov & w_depth_ok;

endmodule

`default_nettype wire

// File: rtl/tile_shader.sv
// ============================================================================
// Module   : tile_shader
// Brief    : Walks a square tile in lane groups, depth-tests and flat-fills.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_shader
    import typhoon_pkg::*;
#(
    parameter int TILE_DIM  = 8,
    parameter int NUM_LANES = 4,
    parameter int COLOR_W   = 16,
    parameter int Z_W       = 16,
    parameter int COORD_W   = 10
) (
    input  wire logic    BOARD_CLK,
    input  wire logic    BOARD_RESET_N,
    tile_shader_if.slave bus
);

    localparam int            AW       = $clog2(TILE_DIM);
    localparam logic [AW-1:0] c_LAST_X = AW'(TILE_DIM - NUM_LANES);
    localparam logic [AW-1:0] c_LAST_Y = AW'(TILE_DIM - 1);
    localparam logic [AW-1:0] c_STEP   = AW'(NUM_LANES);

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_accept;
    logic                 w_last_grp;

    logic [COORD_W-1:0]   r_tile_x;
    logic [COORD_W-1:0]   r_tile_y;
    logic [COORD_W-1:0]   r_box_x;
    logic [COORD_W-1:0]   r_box_y;
    logic [COORD_W-1:0]   r_box_w;
    logic [COORD_W-1:0]   r_box_h;
    logic [COLOR_W-1:0]   r_color;
    logic [Z_W-1:0]       r_frag_z;
    z_mode_e              r_z_mode;

    logic [AW-1:0]        r_rd_x;
    logic [AW-1:0]        r_rd_y;
    logic [AW-1:0]        r_wr_x;
    logic [AW-1:0]        r_wr_y;
    logic                 r_wr_valid;
    logic [NUM_LANES-1:0] w_pass;

    assign w_last_grp = (r_rd_x == c_LAST_X) && (r_rd_y == c_LAST_Y);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_ISSUE;
                    w_accept     = 1'b1;
                end
            end
            ST_ISSUE: if (w_last_grp) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge BOARD_CLK) begin
        if (!BOARD_RESET_N) begin
            r_state    <= ST_IDLE;
            r_tile_x   <= '0;
            r_tile_y   <= '0;
            r_box_x    <= '0;
            r_box_y    <= '0;
            r_box_w    <= '0;
            r_box_h    <= '0;
            r_color    <= '0;
            r_frag_z   <= '0;
            r_z_mode   <= ZM_ALWAYS;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_wr_x     <= '0;
            r_wr_y     <= '0;
            r_wr_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_tile_x <= bus.tile_x;
                r_tile_y <= bus.tile_y;
                r_box_x  <= bus.box_x;
                r_box_y  <= bus.box_y;
                r_box_w  <= bus.box_w;
                r_box_h  <= bus.box_h;
                r_color  <= bus.frag_color;
                r_frag_z <= bus.frag_z;
                r_z_mode <= bus.z_mode;
            end
            // Write side trails the read address by exactly one cycle
            r_wr_valid <= (r_state == ST_ISSUE);
            r_wr_x     <= r_rd_x;
            r_wr_y     <= r_rd_y;
            if (r_state == ST_ISSUE) begin
                if (r_rd_x == c_LAST_X) begin
                    r_rd_x <= '0;
                    r_rd_y <= r_rd_y + AW'(1);
                end else begin
                    r_rd_x <= r_rd_x + c_STEP;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        z_test #(
            .COORD_W (COORD_W),
            .Z_W     (Z_W),
            .AW      (AW),
            .LANE    (i)
        ) u_z_test (
            .i_tile_x (r_tile_x),
            .i_tile_y (r_tile_y),
            .i_grp_x  (r_wr_x),
            .i_grp_y  (r_wr_y),
            .i_box_x  (r_box_x),
            .i_box_y  (r_box_y),
            .i_box_w  (r_box_w),
            .i_box_h  (r_box_h),
            .i_frag_z (r_frag_z),
            .i_rd_z   (bus.rd_z[i*Z_W +: Z_W]),
            .i_z_mode (r_z_mode),
            .o_pass   (w_pass[i])
        );
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.rd_x     = r_rd_x;
    assign bus.rd_y     = r_rd_y;
    assign bus.wr_en    = r_wr_valid ? w_pass : '0;
    assign bus.wr_x     = r_wr_x;
    assign bus.wr_y     = r_wr_y;
    assign bus.wr_color = r_color;
    assign bus.wr_z     = r_frag_z;

endmodule

`default_nettype wire

// File: tb/tb_tile_shader.sv
// ============================================================================
// Module   : tb_tile_shader
// Brief    : Directed vector table plus reset / restart sequences for tile_shader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_shader;
    import typhoon_pkg::*;

    localparam int TILE_DIM  = 8;
    localparam int NUM_LANES = 4;
    localparam int GPR       = TILE_DIM / NUM_LANES;
    localparam int G         = TILE_DIM * TILE_DIM / NUM_LANES;

    typedef struct {
        logic [9:0]  tx, ty, bx, by, bw, bh;
        z_mode_e     zm;
        logic [15:0] fz;
        logic        zsel;
        logic [63:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic zsel;
    int   n_cmp;
    int   n_bad;
    vec_t vt[10];

    tile_shader_if #(.TILE_DIM(TILE_DIM), .NUM_LANES(NUM_LANES), .COLOR_W(16),
                     .Z_W(16), .COORD_W(10)) bus ();

    tile_shader #(.TILE_DIM(TILE_DIM), .NUM_LANES(NUM_LANES), .COLOR_W(16),
                  .Z_W(16), .COORD_W(10)) dut (
        .BOARD_CLK     (clk),
        .BOARD_RESET_N (rst_n),
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Depth memory model: data for the address seen at an edge appears after it
    always @(posedge clk) begin
        if (zsel)
            bus.rd_z <= bus.rd_y[0] ? {4{16'hFFFF}} : {4{16'h0000}};
        else
            bus.rd_z <= {16'hFFFF, 16'h00FF, 16'h0101, 16'h0100};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        bus.tile_x     = v.tx;
        bus.tile_y     = v.ty;
        bus.box_x      = v.bx;
        bus.box_y      = v.by;
        bus.box_w      = v.bw;
        bus.box_h      = v.bh;
        bus.z_mode     = v.zm;
        bus.frag_z     = v.fz;
        bus.frag_color = 16'hC000 + 16'(idx);
        zsel           = v.zsel;
    endtask

    // pre: start was already accepted at the previous edge; restart: raise
    // start in the DONE cycle and keep it high through the following IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx, input bit pre, input bit restart);
        int g;
        if (!pre) begin
            @(negedge clk);
            drive(v, idx);
            bus.start = 1'b1;
            @(negedge clk);
        end
        bus.start      = 1'b0;
        bus.tile_x     = v.tx ^ 10'h155;
        bus.box_x      = v.bx ^ 10'h2AA;
        bus.box_w      = v.bw ^ 10'h3FF;
        bus.box_h      = v.bh ^ 10'h0F0;
        bus.z_mode     = z_mode_e'(~v.zm);
        bus.frag_z     = ~v.fz;
        bus.frag_color = 16'h5A5A;
        for (int c = 1; c <= G + 3; c++) begin
            chk($sformatf("v%0d c%0d busy", idx, c), 64'(bus.busy), 64'(c <= G + 2));
            chk($sformatf("v%0d c%0d done", idx, c), 64'(bus.done), 64'(c == G + 2));
            if (c <= G) begin
                g = c - 1;
                chk($sformatf("v%0d c%0d rd_x", idx, c), 64'(bus.rd_x), 64'((g % GPR) * NUM_LANES));
                chk($sformatf("v%0d c%0d rd_y", idx, c), 64'(bus.rd_y), 64'(g / GPR));
            end
            if (c >= 2 && c <= G + 1) begin
                g = c - 2;
                chk($sformatf("v%0d c%0d wr_en", idx, c), 64'(bus.wr_en), 64'(v.exp[4*g +: 4]));
                chk($sformatf("v%0d c%0d wr_x", idx, c), 64'(bus.wr_x), 64'((g % GPR) * NUM_LANES));
                chk($sformatf("v%0d c%0d wr_y", idx, c), 64'(bus.wr_y), 64'(g / GPR));
            end else begin
                chk($sformatf("v%0d c%0d wr_en idle", idx, c), 64'(bus.wr_en), 64'd0);
            end
            if (c == 2) begin
                chk($sformatf("v%0d color", idx), 64'(bus.wr_color), 64'(16'hC000 + 16'(idx)));
                chk($sformatf("v%0d wr_z", idx), 64'(bus.wr_z), 64'(v.fz));
            end
            if (c == 3) bus.start = 1'b1;
            if (c == 6) bus.start = 1'b0;
            if (restart && c == G + 2) begin
                drive(v, idx);
                bus.start = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        zsel  = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        drive('{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, ZM_ALWAYS, 16'd0, 1'b0, 64'd0}, 0);
        bus.frag_color = 16'd0;

        vt[0] = '{10'd0,    10'd0, 10'd0,    10'd0, 10'd8,  10'd8, ZM_ALWAYS, 16'h0100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[1] = '{10'd8,    10'd8, 10'd10,   10'd9, 10'd3,  10'd2, ZM_ALWAYS, 16'h0100, 1'b0, 64'h0000_0000_001C_1C00};
        vt[2] = '{10'd0,    10'd0, 10'd0,    10'd0, 10'd8,  10'd8, ZM_LESS,   16'h0100, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
        vt[3] = '{10'd0,    10'd0, 10'd0,    10'd0, 10'd8,  10'd8, ZM_LEQUAL, 16'h0100, 1'b0, 64'hBBBB_BBBB_BBBB_BBBB};
        vt[4] = '{10'd0,    10'd0, 10'd0,    10'd0, 10'd0,  10'd8, ZM_ALWAYS, 16'h0100, 1'b0, 64'd0};
        vt[5] = '{10'd0,    10'd0, 10'd0,    10'd0, 10'd8,  10'd8, ZM_NEVER,  16'h0100, 1'b0, 64'd0};
        vt[6] = '{10'd1016, 10'd0, 10'd1020, 10'd0, 10'd10, 10'd8, ZM_ALWAYS, 16'h0100, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0};
        vt[7] = '{10'd0,    10'd0, 10'd1020, 10'd0, 10'd10, 10'd8, ZM_ALWAYS, 16'h0100, 1'b0, 64'd0};
        vt[8] = '{10'd0,    10'd0, 10'd0,    10'd0, 10'd8,  10'd8, ZM_LESS,   16'h0100, 1'b1, 64'hFF00_FF00_FF00_FF00};
        vt[9] = '{10'd0,    10'd0, 10'd1,    10'd1, 10'd2,  10'd8, ZM_ALWAYS, 16'h0100, 1'b0, 64'h0606_0606_0606_0600};

        repeat (3) @(negedge clk);
        chk("rst busy",  64'(bus.busy),     64'd0);
        chk("rst done",  64'(bus.done),     64'd0);
        chk("rst wr_en", 64'(bus.wr_en),    64'd0);
        chk("rst rd_x",  64'(bus.rd_x),     64'd0);
        chk("rst rd_y",  64'(bus.rd_y),     64'd0);
        chk("rst wr_x",  64'(bus.wr_x),     64'd0);
        chk("rst wr_y",  64'(bus.wr_y),     64'd0);
        chk("rst color", 64'(bus.wr_color), 64'd0);
        chk("rst wr_z",  64'(bus.wr_z),     64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vt[i], i, 1'b0, 1'b0);

        // Start in the DONE cycle is ignored, start in the next IDLE cycle is taken
        run_vec(vt[1], 1, 1'b0, 1'b1);
        run_vec(vt[1], 1, 1'b1, 1'b0);

        // Reset in the middle of a tile
        @(negedge clk);
        drive(vt[0], 20);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        chk("mid-rst busy",  64'(bus.busy),  64'd0);
        chk("mid-rst wr_en", 64'(bus.wr_en), 64'd0);
        chk("mid-rst done",  64'(bus.done),  64'd0);
        chk("mid-rst rd_x",  64'(bus.rd_x),  64'd0);
        @(negedge clk);
        chk("rst start ignored", 64'(bus.busy), 64'd0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        for (int c = 0; c < G + 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d wr_en", c), 64'(bus.wr_en), 64'd0);
            chk($sformatf("post-rst c%0d done", c),  64'(bus.done),  64'd0);
            chk($sformatf("post-rst c%0d busy", c),  64'(bus.busy),  64'd0);
        end
        run_vec(vt[1], 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
